// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : shared types, BCD limits and the two-digit BCD incrementer
// Rev 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  // Limits are BCD-encoded so they compare directly against digit pairs
  localparam bcd2_t HUN_MAX = 8'h99;
  localparam bcd2_t SEC_MAX = 8'h59;
  localparam bcd2_t MIN_MAX = 8'h59;

  function automatic bcd2_t bcd2_inc(input bcd2_t v, input bcd2_t max);
    bcd2_t r;
    if (v == max) begin
      r = '0;
    end else if (v.units == 4'd9) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = v.tens;
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : exact-period divider, one strobe every DIV enabled cycles
// Rev 1.0 - initial release
// ============================================================================
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // tick is the wrap strobe for the edge about to happen; the caller registers it
  always_comb begin
    tick  = en && !clr && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_timebase.sv
`default_nettype none
// ============================================================================
// stopwatch_timebase : start/stop/clear FSM with cascaded BCD MM:SS.hh counter
// Optional lap capture when STOPWATCH_LAP_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [7:0] hundredths,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic       running,
  output logic       tick,
  output logic       wrap
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic        lap,
  output logic [23:0] lap_time,
  output logic        lap_valid
`endif
);

  localparam int DIV = CLK_FREQ / TICK_HZ;

  if (((CLK_FREQ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_div
    $error("stopwatch_timebase: CLK_FREQ must be a multiple of TICK_HZ with DIV >= 2");
  end

  sw_state_e state_q, state_d;
  bcd2_t     hun_q, hun_d;
  bcd2_t     sec_q, sec_d;
  bcd2_t     min_q, min_d;
  logic      running_q, running_d;
  logic      tick_q, tick_d;
  logic      wrap_q, wrap_d;
  logic      pre_en, pre_clr, pre_tick;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .nrst (nrst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        RUNNING: state_d = PAUSED;
        default: state_d = RUNNING;
      endcase
    end
  end

  always_comb begin
    pre_en    = (state_q == RUNNING);
    pre_clr   = clear || (state_q == IDLE);
    running_d = (state_d == RUNNING);
  end

  // Carries ripple only on the increment edge, so wrap coincides with tick
  always_comb begin
    hun_d  = hun_q;
    sec_d  = sec_q;
    min_d  = min_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (clear) begin
      hun_d = '0;
      sec_d = '0;
      min_d = '0;
    end else if (pre_tick) begin
      tick_d = 1'b1;
      hun_d  = bcd2_inc(hun_q, HUN_MAX);
      if (hun_q == HUN_MAX) begin
        sec_d = bcd2_inc(sec_q, SEC_MAX);
        if (sec_q == SEC_MAX) begin
          min_d  = bcd2_inc(min_q, MIN_MAX);
          wrap_d = (min_q == MIN_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      hun_q     <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hun_q     <= hun_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign hundredths = hun_q;
  assign seconds    = sec_q;
  assign minutes    = min_q;
  assign running    = running_q;
  assign tick       = tick_q;
  assign wrap       = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic [23:0] lap_time_q, lap_time_d;
  logic        lap_valid_q, lap_valid_d;

  // Captures the post-increment time so a lap on a tick edge matches the display
  always_comb begin
    lap_time_d  = lap_time_q;
    lap_valid_d = 1'b0;
    if (clear) begin
      lap_time_d = '0;
    end else if (lap && (state_q != IDLE)) begin
      lap_time_d  = {min_d, sec_d, hun_d};
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      lap_time_q  <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_time_q  <= lap_time_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_time  = lap_time_q;
  assign lap_valid = lap_valid_q;
`endif

endmodule
`default_nettype wire
